// File: rtl/execute_fsm.sv
// Execute-stage Moore control FSM.
// Sequences datapath strobes for one instruction, then pulses done.
module execute_fsm #(
  parameter int OP_W    = 4,
  parameter bit MFC_POL = 1'b0,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            MFC,
  input  logic [OP_W-1:0] opcode,
  output logic            IR_read,
  output logic            Rsrc_read,
  output logic            Rdst_read,
  output logic            Rdst_write,
  output logic            A_write,
  output logic [1:0]      ALU_op,
  output logic            G_write,
  output logic            G_read,
  output logic            MAR_write,
  output logic            MAR_mem_read,
  output logic            MEM_EN,
  output logic            MEM_RW,
  output logic            MDR_mem_write,
  output logic            MDR_mem_read,
  output logic            MDR_write,
  output logic            MDR_read,
  output logic            PC_load,
  output logic            done,
  output logic            illegal,
  output logic            mem_err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE, DECODE, X1, X2, X3,
    L1, L2, LW, L3, L4,
    S1, S2, S3, SW, J1, DONE
  } state_t;

  state_t          state;
  state_t          nxt;
  logic [OP_W-1:0] op_q;
  logic [CW-1:0]   cnt;
  logic            ill_q;
  logic            err_q;
  logic            in_wait;
  logic            mfc_ok;
  logic            tmo;

  assign in_wait = (state == LW) || (state == SW);
  assign mfc_ok  = (MFC == MFC_POL);
  assign tmo     = in_wait && !mfc_ok && (cnt == LAST);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  // Latched opcode, wait counter and error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      cnt   <= '0;
      ill_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        op_q  <= opcode;
        ill_q <= 1'b0;
        err_q <= 1'b0;
      end
      if (state == DECODE)
        ill_q <= (int'(op_q) > 6);
      if (in_wait) begin
        if (!mfc_ok) cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
      if (tmo) err_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (start) nxt = DECODE;
      DECODE: begin
        case (int'(op_q))
          0:       nxt = DONE;
          1, 2, 3: nxt = X1;
          4:       nxt = L1;
          5:       nxt = S1;
          6:       nxt = J1;
          default: nxt = DONE;
        endcase
      end
      X1:     nxt = X2;
      X2:     nxt = X3;
      X3:     nxt = DONE;
      L1:     nxt = L2;
      L2:     nxt = LW;
      LW: begin
        if (mfc_ok)   nxt = L3;
        else if (tmo) nxt = DONE;
      end
      L3:     nxt = L4;
      L4:     nxt = DONE;
      S1:     nxt = S2;
      S2:     nxt = S3;
      S3:     nxt = SW;
      SW:     if (mfc_ok || tmo) nxt = DONE;
      J1:     nxt = DONE;
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Moore output decode from present state
  always_comb begin
    IR_read       = 1'b0;
    Rsrc_read     = 1'b0;
    Rdst_read     = 1'b0;
    Rdst_write    = 1'b0;
    A_write       = 1'b0;
    ALU_op        = 2'b00;
    G_write       = 1'b0;
    G_read        = 1'b0;
    MAR_write     = 1'b0;
    MAR_mem_read  = 1'b0;
    MEM_EN        = 1'b0;
    MEM_RW        = 1'b0;
    MDR_mem_write = 1'b0;
    MDR_mem_read  = 1'b0;
    MDR_write     = 1'b0;
    MDR_read      = 1'b0;
    PC_load       = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    mem_err       = 1'b0;
    unique case (state)
      X1: begin
        Rsrc_read = 1'b1;
        A_write   = 1'b1;
      end
      X2: begin
        Rdst_read = 1'b1;
        G_write   = 1'b1;
        if (int'(op_q) == 2)      ALU_op = 2'b01;
        else if (int'(op_q) == 3) ALU_op = 2'b10;
      end
      X3: begin
        G_read     = 1'b1;
        Rdst_write = 1'b1;
      end
      L1, S1: begin
        IR_read   = 1'b1;
        MAR_write = 1'b1;
      end
      L2, LW: begin
        MAR_mem_read = 1'b1;
        MEM_EN       = 1'b1;
        MEM_RW       = 1'b1;
      end
      L3: MDR_mem_write = 1'b1;
      L4: begin
        MDR_read   = 1'b1;
        Rdst_write = 1'b1;
      end
      S2: begin
        Rsrc_read = 1'b1;
        MDR_write = 1'b1;
      end
      S3, SW: begin
        MAR_mem_read = 1'b1;
        MDR_mem_read = 1'b1;
        MEM_EN       = 1'b1;
      end
      J1: begin
        IR_read = 1'b1;
        PC_load = 1'b1;
      end
      DONE: begin
        done    = 1'b1;
        illegal = ill_q;
        mem_err = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_execute_fsm.sv
// Bench for execute_fsm.
// Instruction-level model builds the expected per-cycle output trace.
module tb_execute_fsm;

  localparam bit POL = 1'b0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       MFC = 1'b1;
  logic [3:0] opcode = '0;
  logic       IR_read, Rsrc_read, Rdst_read, Rdst_write, A_write;
  logic [1:0] ALU_op;
  logic       G_write, G_read, MAR_write, MAR_mem_read, MEM_EN, MEM_RW;
  logic       MDR_mem_write, MDR_mem_read, MDR_write, MDR_read, PC_load;
  logic       done, illegal, mem_err;

  execute_fsm #(.OP_W(4), .MFC_POL(POL), .TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .start(start), .MFC(MFC), .opcode(opcode),
    .IR_read(IR_read), .Rsrc_read(Rsrc_read), .Rdst_read(Rdst_read),
    .Rdst_write(Rdst_write), .A_write(A_write), .ALU_op(ALU_op),
    .G_write(G_write), .G_read(G_read), .MAR_write(MAR_write),
    .MAR_mem_read(MAR_mem_read), .MEM_EN(MEM_EN), .MEM_RW(MEM_RW),
    .MDR_mem_write(MDR_mem_write), .MDR_mem_read(MDR_mem_read),
    .MDR_write(MDR_write), .MDR_read(MDR_read), .PC_load(PC_load),
    .done(done), .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ir_rd, rsrc_rd, rdst_rd, rdst_wr, a_wr;
    logic [1:0] alu;
    logic       g_wr, g_rd, mar_wr, mar_mem_rd, mem_en, mem_rw;
    logic       mdr_mem_wr, mdr_mem_rd, mdr_wr, mdr_rd, pc_ld;
    logic       dn, ill, merr;
  } out_t;

  typedef struct {
    out_t o;
    bit   idle;
    bit   care;
    bit   mfc;
    bit   wt;
  } step_t;

  out_t  dut_o;
  assign dut_o = {IR_read, Rsrc_read, Rdst_read, Rdst_write, A_write,
                  ALU_op, G_write, G_read, MAR_write, MAR_mem_read,
                  MEM_EN, MEM_RW, MDR_mem_write, MDR_mem_read,
                  MDR_write, MDR_read, PC_load, done, illegal, mem_err};

  step_t exp_q[$];
  step_t cur;
  step_t idle_s;
  int    n_vec = 0;
  int    n_err = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    done_lat = -1;

  function automatic step_t stp(input out_t o);
    step_t s;
    s.o = o; s.idle = 1'b0; s.care = 1'b0; s.mfc = 1'b0; s.wt = 1'b0;
    return s;
  endfunction

  // k = MFC-incomplete WAIT cycles before completion; k>=15 never completes
  task automatic build(input int op, input int k);
    out_t  o;
    step_t s;
    int    nw;
    bit    tmo;
    tmo = 1'b0;
    o = '0; exp_q.push_back(stp(o));
    if (op >= 1 && op <= 3) begin
      o = '0; o.rsrc_rd = 1; o.a_wr = 1; exp_q.push_back(stp(o));
      o = '0; o.rdst_rd = 1; o.g_wr = 1; o.alu = 2'(op - 1);
      exp_q.push_back(stp(o));
      o = '0; o.g_rd = 1; o.rdst_wr = 1; exp_q.push_back(stp(o));
    end else if (op == 4 || op == 5) begin
      o = '0; o.ir_rd = 1; o.mar_wr = 1; exp_q.push_back(stp(o));
      if (op == 5) begin
        o = '0; o.rsrc_rd = 1; o.mdr_wr = 1; exp_q.push_back(stp(o));
      end
      o = '0; o.mar_mem_rd = 1; o.mem_en = 1;
      o.mem_rw = (op == 4); o.mdr_mem_rd = (op == 5);
      exp_q.push_back(stp(o));
      tmo = (k >= 15);
      nw = tmo ? 15 : k + 1;
      for (int i = 0; i < nw; i++) begin
        s = stp(o); s.wt = 1; s.care = 1;
        s.mfc = (i < k) ? ~POL : POL;
        exp_q.push_back(s);
      end
      if (op == 4 && !tmo) begin
        o = '0; o.mdr_mem_wr = 1; exp_q.push_back(stp(o));
        o = '0; o.mdr_rd = 1; o.rdst_wr = 1; exp_q.push_back(stp(o));
      end
    end else if (op == 6) begin
      o = '0; o.ir_rd = 1; o.pc_ld = 1; exp_q.push_back(stp(o));
    end
    o = '0; o.dn = 1; o.ill = (op > 6); o.merr = tmo;
    exp_q.push_back(stp(o));
  endtask

  // One cycle: compare at negedge, drive, advance model
  task automatic tick(input bit dir, input bit want_start,
                      input int want_op, input int want_k);
    bit st;
    int op;
    int k;
    n_vec++;
    if (dut_o !== cur.o) begin
      n_err++;
      $display("FAIL cycle %0d outputs: got %h expected %h",
               cyc, dut_o, cur.o);
    end
    if (done === 1'b1) done_lat = cyc - start_cyc;
    st = dir ? want_start : ($urandom_range(0, 2) != 0);
    op = dir ? want_op : int'($urandom_range(0, 15));
    if ($urandom_range(0, 7) == 0) k = int'($urandom_range(3, 20));
    else k = int'($urandom_range(0, 3));
    if (dir) k = want_k;
    if (cur.idle) begin
      if (st) begin
        build(op, k);
        start_cyc = cyc;
      end
    end else begin
      st = 1'($urandom_range(0, 1));
      op = int'($urandom_range(0, 15));
    end
    start  = st;
    opcode = 4'(op);
    MFC    = cur.care ? cur.mfc : 1'($urandom_range(0, 1));
    @(posedge clk);
    cyc++;
    if (exp_q.size() != 0) cur = exp_q.pop_front();
    else cur = idle_s;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic to_idle();
    for (int i = 0; i < 40 && !cur.idle; i++) tick(1'b1, 1'b0, 0, 0);
  endtask

  task automatic run_one(input string name, input int op,
                         input int k, input int lat);
    int i;
    to_idle();
    done_lat = -1;
    tick(1'b1, 1'b1, op, k);
    for (i = 0; i < 40 && !cur.idle; i++) tick(1'b1, 1'b0, 0, 0);
    if (!cur.idle) begin
      n_err++;
      $display("FAIL %s: model did not return to idle", name);
    end
    pin(name, done_lat, lat);
  endtask

  initial begin
    idle_s = stp('0);
    idle_s.idle = 1'b1;
    cur = idle_s;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (dut_o !== '0) begin
      n_err++;
      $display("FAIL reset_state: got %h expected 0", dut_o);
    end
    reset = 1'b0;

    run_one("add_lat",        1, 0, 5);
    run_one("sub_lat",        2, 0, 5);
    run_one("and_lat",        3, 0, 5);
    run_one("nop_lat",        0, 0, 2);
    run_one("load_k3_lat",    4, 3, 10);
    run_one("load_k0_lat",    4, 0, 7);
    run_one("store_k0_lat",   5, 0, 6);
    run_one("jmp_lat",        6, 0, 3);
    run_one("illegal_lat",    9, 0, 2);
    run_one("load_tmo_lat",   4, 20, 19);
    run_one("store_tmo_lat",  5, 20, 20);
    run_one("load_k14_lat",   4, 14, 21);

    for (int i = 0; i < 1500; i++) tick(1'b0, 1'b0, 0, 0);

    to_idle();
    tick(1'b1, 1'b1, 4, 20);
    for (int i = 0; i < 40 && !cur.wt; i++) tick(1'b1, 1'b0, 0, 0);
    tick(1'b1, 1'b0, 0, 0);
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (dut_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid_wait: got %h expected 0", dut_o);
    end
    exp_q.delete();
    cur = idle_s;
    @(negedge clk);
    reset = 1'b0;
    run_one("nop_after_reset", 0, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
